// File: rtl/param_bus_arbiter_if.sv
// rtl/param_bus_arbiter_if.sv - patch-parameter bus and CC/SysEx requester handshakes
interface param_bus_arbiter_if;
   // Real-time MIDI CC requester
   logic       cc_req;
   logic       cc_we;
   logic [1:0] cc_bank;
   logic [6:0] cc_adr;
   logic [7:0] cc_wdata;
   logic       cc_gnt;

   // SysEx patch engine requester
   logic       sx_req;
   logic       sx_we;
   logic [1:0] sx_bank;
   logic [6:0] sx_adr;
   logic [7:0] sx_wdata;
   logic       sx_last;
   logic       sx_gnt;

   // Shared read return
   logic [7:0] rdata;

   // Register-file side
   logic [6:0] bus_adr;
   logic [7:0] bus_wdata;
   logic [7:0] bus_rdata;
   logic       write;
   logic       read;
   logic       osc_sel;
   logic       com_sel;
   logic       m1_sel;
   logic       m2_sel;

   // Burst status
   logic       sysex_data_patch_send;
   logic       sx_abort;

   // master: the arbiter, which owns the register-file bus and issues grants
   modport master (
      input  cc_req, cc_we, cc_bank, cc_adr, cc_wdata,
      input  sx_req, sx_we, sx_bank, sx_adr, sx_wdata, sx_last,
      input  bus_rdata,
      output cc_gnt, sx_gnt, rdata,
      output bus_adr, bus_wdata, write, read,
      output osc_sel, com_sel, m1_sel, m2_sel,
      output sysex_data_patch_send, sx_abort
   );

   // slave: requesters and register file as seen from outside the arbiter
   modport slave (
      output cc_req, cc_we, cc_bank, cc_adr, cc_wdata,
      output sx_req, sx_we, sx_bank, sx_adr, sx_wdata, sx_last,
      output bus_rdata,
      input  cc_gnt, sx_gnt, rdata,
      input  bus_adr, bus_wdata, write, read,
      input  osc_sel, com_sel, m1_sel, m2_sel,
      input  sysex_data_patch_send, sx_abort
   );
endinterface

// File: rtl/param_bus_arbiter.sv
// rtl/param_bus_arbiter.sv - CC/SysEx patch-parameter bus arbiter; burst watchdog under PARAM_BUS_WATCHDOG_EN
module param_bus_arbiter #(
   parameter int READ_LAT = 2,
   parameter int MAX_WAIT = 16
`ifdef PARAM_BUS_WATCHDOG_EN
   ,
   parameter int TIMEOUT  = 255
`endif
) (
   input logic                 sCLK_XVXENVS,
   input logic                 reset_data,
   param_bus_arbiter_if.master pb
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      STROBE  = 3'd2,
      WAIT_RD = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam int             WCW          = $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0] WAIT_FULL    = WCW'(MAX_WAIT);
   localparam logic [2:0]     RD_WAIT_LAST = 3'(READ_LAT - 1);

   state_t         state_q;
   state_t         state_d;

   // Captured access: who owns it and what it does
   logic           owner_sx_q;
   logic           we_q;
   logic           last_q;
   logic [1:0]     bank_q;
   logic [6:0]     adr_q;
   logic [7:0]     wdata_q;
   logic [7:0]     rd_q;
   logic [2:0]     lat_q;

   // Burst ownership and CC starvation guard
   logic           lock_q;
   logic           send_q;
   logic [WCW-1:0] wait_q;

   // Arbitration decisions, only meaningful in IDLE
   logic           cc_turn;
   logic           sx_turn;
   logic           cc_busy;
   logic           wd_fire;

   // Decoded outputs
   logic           cc_gnt_c;
   logic           sx_gnt_c;
   logic           write_c;
   logic           read_c;
   logic [3:0]     sel_c;
   logic [7:0]     rdata_c;

   // A CC access in flight must not count against its own wait budget
   assign cc_busy = (state_q != IDLE) && !owner_sx_q;

   // State register; reset drops any in-flight access without a grant
   always_ff @(posedge sCLK_XVXENVS or posedge reset_data) begin
      if (reset_data) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, arbitration and per-state bus outputs
   always_comb begin
      state_d  = state_q;
      cc_turn  = 1'b0;
      sx_turn  = 1'b0;
      cc_gnt_c = 1'b0;
      sx_gnt_c = 1'b0;
      write_c  = 1'b0;
      read_c   = 1'b0;
      sel_c    = 4'b0000;
      rdata_c  = 8'h00;
      case (state_q)
         IDLE: begin
            // CC wins unless a burst holds the lock; a full wait counter
            // lets exactly one CC access through an open burst
            cc_turn = pb.cc_req && (!lock_q || (wait_q == WAIT_FULL));
            sx_turn = pb.sx_req && !cc_turn;
            if (cc_turn || sx_turn) begin
               state_d = SETUP;
            end
         end
         SETUP: begin
            sel_c   = 4'b0001 << bank_q;
            state_d = STROBE;
         end
         STROBE: begin
            sel_c   = 4'b0001 << bank_q;
            write_c = we_q;
            read_c  = !we_q;
            if (we_q || (READ_LAT == 1)) begin
               state_d = DONE;
            end else begin
               state_d = WAIT_RD;
            end
         end
         WAIT_RD: begin
            sel_c = 4'b0001 << bank_q;
            if (lat_q == RD_WAIT_LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            cc_gnt_c = !owner_sx_q;
            sx_gnt_c = owner_sx_q;
            if (!we_q) begin
               rdata_c = rd_q;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Capture the winner's request at the IDLE->SETUP edge and the read
   // return on the edge entering DONE
   always_ff @(posedge sCLK_XVXENVS or posedge reset_data) begin
      if (reset_data) begin
         owner_sx_q <= 1'b0;
         we_q       <= 1'b0;
         last_q     <= 1'b0;
         bank_q     <= 2'd0;
         adr_q      <= 7'h00;
         wdata_q    <= 8'h00;
         rd_q       <= 8'h00;
      end else begin
         if (cc_turn) begin
            owner_sx_q <= 1'b0;
            we_q       <= pb.cc_we;
            last_q     <= 1'b0;
            bank_q     <= pb.cc_bank;
            adr_q      <= pb.cc_adr;
            wdata_q    <= pb.cc_wdata;
         end else if (sx_turn) begin
            owner_sx_q <= 1'b1;
            we_q       <= pb.sx_we;
            last_q     <= pb.sx_last;
            bank_q     <= pb.sx_bank;
            adr_q      <= pb.sx_adr;
            wdata_q    <= pb.sx_wdata;
         end
         if ((state_q != DONE) && (state_d == DONE) && !we_q) begin
            rd_q <= pb.bus_rdata;
         end
      end
   end

   // Count cycles spent in WAIT_RD so the read return lines up with READ_LAT
   always_ff @(posedge sCLK_XVXENVS or posedge reset_data) begin
      if (reset_data) begin
         lat_q <= 3'd0;
      end else begin
         lat_q <= (state_d == WAIT_RD) ? lat_q + 3'd1 : 3'd0;
      end
   end

   // Burst lock, dump flag and CC starvation counter
   always_ff @(posedge sCLK_XVXENVS or posedge reset_data) begin
      if (reset_data) begin
         lock_q <= 1'b0;
         send_q <= 1'b0;
         wait_q <= '0;
      end else begin
         if (sx_turn) begin
            lock_q <= 1'b1;
            // Only the first access of a burst decides dump versus load
            if (!lock_q) begin
               send_q <= !pb.sx_we;
            end
         end else if (((state_q == DONE) && owner_sx_q && last_q) || wd_fire) begin
            lock_q <= 1'b0;
            send_q <= 1'b0;
         end

         if (cc_turn || !lock_q) begin
            wait_q <= '0;
         end else if (pb.cc_req && !cc_busy && (wait_q != WAIT_FULL)) begin
            wait_q <= wait_q + WCW'(1);
         end
      end
   end

`ifdef PARAM_BUS_WATCHDOG_EN
   localparam int WDW = $clog2(TIMEOUT + 1);

   logic [WDW-1:0] wd_q;
   logic           abort_q;
   logic           wd_idle;

   // An open burst that leaves the bus idle with no SysEx request is stalling
   assign wd_idle = lock_q && (state_q == IDLE) && !pb.sx_req;
   assign wd_fire = wd_idle && (wd_q == WDW'(TIMEOUT - 1));

   // Watchdog: release a stalled burst after TIMEOUT idle cycles
   always_ff @(posedge sCLK_XVXENVS or posedge reset_data) begin
      if (reset_data) begin
         wd_q    <= '0;
         abort_q <= 1'b0;
      end else begin
         abort_q <= wd_fire;
         if (!wd_idle || wd_fire) begin
            wd_q <= '0;
         end else begin
            wd_q <= wd_q + WDW'(1);
         end
      end
   end

   assign pb.sx_abort = abort_q;
`else
   assign wd_fire     = 1'b0;
   assign pb.sx_abort = 1'b0;
`endif

   assign pb.cc_gnt                = cc_gnt_c;
   assign pb.sx_gnt                = sx_gnt_c;
   assign pb.rdata                 = rdata_c;
   assign pb.bus_adr               = adr_q;
   assign pb.bus_wdata             = wdata_q;
   assign pb.write                 = write_c;
   assign pb.read                  = read_c;
   assign pb.osc_sel               = sel_c[0];
   assign pb.com_sel               = sel_c[1];
   assign pb.m1_sel                = sel_c[2];
   assign pb.m2_sel                = sel_c[3];
   assign pb.sysex_data_patch_send = send_q;

endmodule

// File: tb/tb_param_bus_arbiter.sv
// tb/tb_param_bus_arbiter.sv - directed-vector bench for param_bus_arbiter
module tb_param_bus_arbiter;

   localparam logic [31:0] F_CCG  = 32'h100;
   localparam logic [31:0] F_SXG  = 32'h080;
   localparam logic [31:0] F_WR   = 32'h040;
   localparam logic [31:0] F_RD   = 32'h020;
   localparam logic [31:0] F_OSC  = 32'h010;
   localparam logic [31:0] F_COM  = 32'h008;
   localparam logic [31:0] F_M1   = 32'h004;
   localparam logic [31:0] F_M2   = 32'h002;
   localparam logic [31:0] F_SEND = 32'h001;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rd_d1 = 1'b0;
   logic [7:0] rf_val = 8'h00;

   int vec_cnt = 0;
   int err_cnt = 0;

   param_bus_arbiter_if bus ();

   param_bus_arbiter #(
      .READ_LAT (2),
      .MAX_WAIT (16)
`ifdef PARAM_BUS_WATCHDOG_EN
      ,
      .TIMEOUT  (10)
`endif
   ) dut (
      .sCLK_XVXENVS (clk),
      .reset_data   (rst),
      .pb           (bus)
   );

   always #5 clk = ~clk;

   // Register-file model: data is presented during the cycle after the read
   // strobe and captured by the arbiter on the edge that ends it
   always @(posedge clk) rd_d1 <= bus.read;
   assign bus.bus_rdata = rd_d1 ? rf_val : 8'hEE;

   wire [31:0] flags = {23'd0, bus.cc_gnt, bus.sx_gnt, bus.write, bus.read,
                        bus.osc_sel, bus.com_sel, bus.m1_sel, bus.m2_sel,
                        bus.sysex_data_patch_send};

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive_cc(input logic we, input logic [1:0] bank, input logic [6:0] adr, input logic [7:0] wd);
      bus.cc_we    = we;
      bus.cc_bank  = bank;
      bus.cc_adr   = adr;
      bus.cc_wdata = wd;
      bus.cc_req   = 1'b1;
   endtask

   task automatic drive_sx(input logic we, input logic [1:0] bank, input logic [6:0] adr, input logic [7:0] wd, input logic last);
      bus.sx_we    = we;
      bus.sx_bank  = bank;
      bus.sx_adr   = adr;
      bus.sx_wdata = wd;
      bus.sx_last  = last;
      bus.sx_req   = 1'b1;
   endtask

   int sx_cnt;
   int cc_cnt;
   int sx_before_cc;
   int send_mid;
   int abort_cnt;
   int abort_at;
   int cc_at;
   int send_at_cc;

   initial begin
      bus.cc_req = 1'b0; bus.cc_we = 1'b0; bus.cc_bank = 2'd0; bus.cc_adr = 7'h00; bus.cc_wdata = 8'h00;
      bus.sx_req = 1'b0; bus.sx_we = 1'b0; bus.sx_bank = 2'd0; bus.sx_adr = 7'h00; bus.sx_wdata = 8'h00;
      bus.sx_last = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check_vec("rst_flags", flags, 32'h0);
      check_vec("rst_adr", 32'(bus.bus_adr), 32'h0);
      check_vec("rst_rdata", 32'(bus.rdata), 32'h0);
      check_vec("rst_abort", 32'(bus.sx_abort), 32'h0);
      rst = 1'b0;

      // CC write, bank 2
      @(negedge clk);
      drive_cc(1'b1, 2'd2, 7'h15, 8'h5A);
      @(negedge clk);
      check_vec("t1_c1", flags, F_M1);
      check_vec("t1_adr", 32'(bus.bus_adr), 32'h15);
      check_vec("t1_wdata", 32'(bus.bus_wdata), 32'h5A);
      @(negedge clk);
      check_vec("t1_c2", flags, F_M1 | F_WR);
      @(negedge clk);
      check_vec("t1_c3", flags, F_CCG);
      check_vec("t1_rdata", 32'(bus.rdata), 32'h0);
      bus.cc_req = 1'b0;
      @(negedge clk);
      check_vec("t1_c4", flags, 32'h0);
      check_vec("t1_adr_hold", 32'(bus.bus_adr), 32'h15);

      // CC read, bank 0
      rf_val = 8'h7F;
      drive_cc(1'b0, 2'd0, 7'h03, 8'h00);
      @(negedge clk);
      check_vec("t2_c1", flags, F_OSC);
      @(negedge clk);
      check_vec("t2_c2", flags, F_OSC | F_RD);
      @(negedge clk);
      check_vec("t2_c3", flags, F_OSC);
      @(negedge clk);
      check_vec("t2_c4", flags, F_CCG);
      check_vec("t2_rdata", 32'(bus.rdata), 32'h7F);
      bus.cc_req = 1'b0;
      @(negedge clk);
      check_vec("t2_c5", flags, 32'h0);
      check_vec("t2_rdata_idle", 32'(bus.rdata), 32'h0);

      // Simultaneous CC write and single-access SysEx read
      drive_cc(1'b1, 2'd1, 7'h20, 8'h11);
      drive_sx(1'b0, 2'd3, 7'h40, 8'h00, 1'b1);
      @(negedge clk);
      check_vec("t3_c1", flags, F_COM);
      @(negedge clk);
      check_vec("t3_c2", flags, F_COM | F_WR);
      @(negedge clk);
      check_vec("t3_c3", flags, F_CCG);
      bus.cc_req = 1'b0;
      @(negedge clk);
      check_vec("t3_c4", flags, 32'h0);
      @(negedge clk);
      check_vec("t3_c5", flags, F_M2 | F_SEND);
      check_vec("t3_adr", 32'(bus.bus_adr), 32'h40);
      @(negedge clk);
      check_vec("t3_c6", flags, F_M2 | F_RD | F_SEND);
      @(negedge clk);
      check_vec("t3_c7", flags, F_M2 | F_SEND);
      @(negedge clk);
      check_vec("t3_c8", flags, F_SXG | F_SEND);
      check_vec("t3_rdata", 32'(bus.rdata), 32'h7F);
      bus.sx_req = 1'b0;
      @(negedge clk);
      check_vec("t3_c9", flags, 32'h0);

      // 40-access SysEx dump with a CC request held from the second access
      sx_cnt = 0; cc_cnt = 0; sx_before_cc = -1; send_mid = 0;
      drive_sx(1'b0, 2'd2, 7'h00, 8'h00, 1'b0);
      for (int cyc = 0; cyc < 400 && sx_cnt < 40; cyc++) begin
         @(negedge clk);
         if (bus.cc_gnt) begin
            cc_cnt++;
            sx_before_cc = sx_cnt;
            bus.cc_req = 1'b0;
         end
         if (bus.sx_gnt) begin
            sx_cnt++;
            if (sx_cnt == 1) drive_cc(1'b1, 2'd1, 7'h01, 8'h22);
            if (sx_cnt == 20) send_mid = int'(bus.sysex_data_patch_send);
            if (sx_cnt == 40) begin
               bus.sx_req = 1'b0;
            end else begin
               bus.sx_adr  = 7'(sx_cnt);
               bus.sx_last = (sx_cnt == 39);
            end
         end
      end
      check_vec("t4_sx_count", sx_cnt, 40);
      check_vec("t4_cc_count", cc_cnt, 1);
      check_vec("t4_cc_position", sx_before_cc, 4);
      check_vec("t4_send_mid", send_mid, 1);
      @(negedge clk);
      check_vec("t4_after", flags, 32'h0);

      // Reset during STROBE of a SysEx write that opens a burst
      drive_sx(1'b1, 2'd1, 7'h33, 8'h44, 1'b0);
      @(negedge clk);
      check_vec("t5_c1", flags, F_COM);
      @(negedge clk);
      check_vec("t5_c2", flags, F_COM | F_WR);
      rst = 1'b1;
      drive_cc(1'b1, 2'd3, 7'h05, 8'h66);
      #1;
      check_vec("t5_rst_flags", flags, 32'h0);
      check_vec("t5_rst_adr", 32'(bus.bus_adr), 32'h0);
      check_vec("t5_rst_wdata", 32'(bus.bus_wdata), 32'h0);
      @(negedge clk);
      check_vec("t5_rst_hold", flags, 32'h0);
      rst = 1'b0;
      bus.sx_last = 1'b1;
      @(negedge clk);
      check_vec("t5_cc_c1", flags, F_M2);
      @(negedge clk);
      check_vec("t5_cc_c2", flags, F_M2 | F_WR);
      @(negedge clk);
      check_vec("t5_cc_c3", flags, F_CCG);
      bus.cc_req = 1'b0;
      @(negedge clk);
      check_vec("t5_c4", flags, 32'h0);
      @(negedge clk);
      check_vec("t5_sx_c5", flags, F_COM);
      @(negedge clk);
      check_vec("t5_sx_c6", flags, F_COM | F_WR);
      @(negedge clk);
      check_vec("t5_sx_c7", flags, F_SXG);
      bus.sx_req = 1'b0;

      // Open a dump burst, stall it, and request CC meanwhile
      @(negedge clk);
      drive_sx(1'b0, 2'd0, 7'h10, 8'h00, 1'b0);
      repeat (4) @(negedge clk);
      check_vec("t6_c4", flags, F_SXG | F_SEND);
      bus.sx_req = 1'b0;
      drive_cc(1'b1, 2'd2, 7'h0A, 8'h99);
      abort_cnt = 0; abort_at = -1; cc_at = -1; send_at_cc = -1;
      for (int k = 5; k <= 40; k++) begin
         @(negedge clk);
         if (bus.sx_abort) begin
            abort_cnt++;
            abort_at = k;
         end
         if (bus.cc_gnt) begin
            cc_at = k;
            send_at_cc = int'(bus.sysex_data_patch_send);
            bus.cc_req = 1'b0;
         end
      end
`ifdef PARAM_BUS_WATCHDOG_EN
      check_vec("t6_abort_count", abort_cnt, 1);
      check_vec("t6_abort_cycle", abort_at, 15);
      check_vec("t6_cc_cycle", cc_at, 18);
      check_vec("t6_send_at_cc", send_at_cc, 0);
`else
      check_vec("t6_abort_count", abort_cnt, 0);
      check_vec("t6_cc_cycle", cc_at, 23);
      check_vec("t6_send_at_cc", send_at_cc, 1);
      drive_sx(1'b0, 2'd0, 7'h11, 8'h00, 1'b1);
      for (int k = 0; k < 10 && !bus.sx_gnt; k++) @(negedge clk);
      check_vec("t6_close_gnt", 32'(bus.sx_gnt), 32'h1);
      bus.sx_req = 1'b0;
`endif
      @(negedge clk);
      check_vec("t6_end", flags, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
